// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with burst locking for a shared 4:1 mux tree.
// One requester owns the resource until its burst ends by a last beat,
// by reaching MAX_BURST beats, or by dropping its request. On burst end
// the next owner is picked on the same edge, so there is no bubble cycle.
module mux_rr_arbiter #(
  parameter int N         = 4,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic [N-1:0] last,
  input  logic         ready,
  output logic [N-1:0] grant,
  output logic [1:0]   sel,
  output logic         busy,
  output logic         beat
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t       state, state_n;
  logic [1:0]   ptr, ptr_n;
  logic [3:0]   cnt, cnt_n;
  logic [1:0]   sel_n;
  logic [N-1:0] grant_n;
  logic [N-1:0] cand;
  logic [1:0]   scan_from;
  logic         arb;
  logic [2:0]   pick;

  // First set bit of r scanning start, start+1, ... with wrap.
  // Returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [N-1:0] r,
                                         input logic [1:0]   start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = N - 1; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign busy = (state == OWN);
  assign beat = busy & req[sel] & ready;

  // Next-state: burst bookkeeping, then a shared arbitration step used
  // both when leaving IDLE and when a burst ends.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = cnt;
    sel_n     = sel;
    grant_n   = grant;
    cand      = req;
    scan_from = ptr;
    arb       = 1'b0;
    pick      = 3'b000;
    case (state)
      IDLE: begin
        if (|req) arb = 1'b1;
      end
      OWN: begin
        if (!req[sel]) begin
          // abandon: owner gave up, it must not win the re-arbitration
          arb         = 1'b1;
          cand[sel]   = 1'b0;
        end else if (beat && last[sel]) begin
          arb         = 1'b1;
          cand[sel]   = 1'b0;
        end else if (beat && (cnt + 4'd1 == 4'(MAX_BURST))) begin
          // forced release: owner stays eligible but is scanned last
          arb         = 1'b1;
        end else if (beat) begin
          cnt_n       = cnt + 4'd1;
        end
        if (arb) begin
          ptr_n     = sel + 2'd1;
          scan_from = sel + 2'd1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (arb) begin
      pick  = rr_pick(cand, scan_from);
      cnt_n = 4'd0;
      if (pick[2]) begin
        state_n = OWN;
        sel_n   = pick[1:0];
        grant_n = N'(1) << pick[1:0];
      end else begin
        state_n = IDLE;
        grant_n = '0;
      end
    end
  end

  // State register; reset wins over any burst in progress.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 2'd0;
      cnt   <= 4'd0;
      sel   <= 2'd0;
      grant <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      sel   <= sel_n;
      grant <= grant_n;
    end
  end

endmodule
